line_capture: RTL and testbench

- Downstream consumer of the per-line column counter.
- Samples one pixel per clk into a ping-pong line buffer. The column counter value is the write address, and capture is armed by the HSYNC pulse that clears that counter.
- Completed lines are streamed out on a valid/ready interface to the next processing stage.
- Two banks let line N be drained while line N+1 is captured.

---
 rtl/line_capture_pkg.sv | 17 +
 rtl/line_capture_if.sv | 30 +++
 rtl/line_bank_ram.sv | 28 ++
 rtl/line_capture.sv | 155 +++++++++++++++
 tb/tb_line_capture.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/line_capture_pkg.sv
// line_capture shared types and constants.
// FSM state encodings and drop counter width.
package line_capture_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_CAPT = 1'b1
  } wr_st_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_st_t;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/line_capture_if.sv
// line_capture output stream bundle.
// valid/ready pixel stream with column tag and line-end marker.
interface line_capture_if #(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 8
) ();

  logic [PWIDTH-1:0] out_data;
  logic [DWIDTH-1:0] out_col;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_col,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_col,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/line_bank_ram.sv
// Two-bank line RAM, address {bank, col}.
// One write port, one registered read port, no reset.
module line_bank_ram #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // capture side write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // one-cycle read for the stream side
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_capture.sv
// Ping-pong line capture: hsync-armed write into two banks,
// completed lines streamed out over valid/ready.
module line_capture
  import line_capture_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsync,
  input  logic [DWIDTH-1:0]     col,
  input  logic [PWIDTH-1:0]     pix_in,
  line_capture_if.master        ob,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [DWIDTH-1:0] COL_MAX = '1;

  wr_st_t wst;
  rd_st_t rst_st;

  logic              hs_q;
  logic              hs_rise;
  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic              we;
  logic              wr_done;
  logic              rd_done;
  logic              re;
  logic              load;
  logic              q_vld;
  logic              issued;
  logic [DWIDTH-1:0] raddr;
  logic [DWIDTH-1:0] q_col;
  logic [PWIDTH-1:0] rdata;

  assign hs_rise = hsync & ~hs_q;
  assign we      = (wst == W_CAPT) & ~hsync;
  assign wr_done = we & (col == COL_MAX);
  assign rd_done = ob.out_valid & ob.out_ready & ob.out_last;
  assign load    = q_vld & (~ob.out_valid | ob.out_ready);
  assign re      = (rst_st == R_IDLE) ? full[rd_bank]
                 : (~issued & (~q_vld | load));

  line_bank_ram #(
    .AW (DWIDTH + 1),
    .DW (PWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wr_bank, col}),
    .wdata (pix_in),
    .re    (re),
    .raddr ({rd_bank, raddr}),
    .rdata (rdata)
  );

  // write FSM: arm on hsync edge, drop line if target bank still full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q     <= 1'b0;
      wst      <= W_IDLE;
      wr_bank  <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      hs_q <= hsync;
      unique case (wst)
        W_IDLE: begin
          if (hs_rise) begin
            if (!full[wr_bank]) begin
              wst <= W_CAPT;
            end else begin
              overflow <= 1'b1;
              if (drop_cnt != '1)
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
          end
        end
        W_CAPT: begin
          if (wr_done) begin
            wr_bank <= ~wr_bank;
            wst     <= W_IDLE;
          end
        end
        default: wst <= W_IDLE;
      endcase
    end
  end

  // bank full flags: set by writer, cleared by reader, never same bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 2'b00;
    end else begin
      if (wr_done) full[wr_bank] <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  // read FSM and RAM prefetch tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_st  <= R_IDLE;
      rd_bank <= 1'b0;
      raddr   <= '0;
      q_col   <= '0;
      issued  <= 1'b0;
      q_vld   <= 1'b0;
    end else begin
      q_vld <= re | (q_vld & ~load);
      if (re) begin
        raddr <= raddr + DWIDTH'(1);
        q_col <= raddr;
        if (raddr == COL_MAX) issued <= 1'b1;
      end
      unique case (rst_st)
        R_IDLE: begin
          if (full[rd_bank]) rst_st <= R_READ;
        end
        R_READ: begin
          if (rd_done) begin
            rst_st  <= R_IDLE;
            rd_bank <= ~rd_bank;
            issued  <= 1'b0;
            raddr   <= '0;
          end
        end
        default: rst_st <= R_IDLE;
      endcase
    end
  end

  // output register: refill from prefetched word when empty or accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob.out_valid <= 1'b0;
      ob.out_last  <= 1'b0;
      ob.out_data  <= '0;
      ob.out_col   <= '0;
    end else if (load) begin
      ob.out_valid <= 1'b1;
      ob.out_last  <= (q_col == COL_MAX);
      ob.out_data  <= rdata;
      ob.out_col   <= q_col;
    end else if (ob.out_ready) begin
      ob.out_valid <= 1'b0;
      ob.out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_capture.sv
// line_capture bench: directed lines, queue scoreboard of
// expected beats, hold checks under backpressure.
module tb_line_capture;

  localparam int DW = 3;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hsync = 1'b0;
  logic [DW-1:0] col = '0;
  logic [PW-1:0] pix_in = '0;
  logic          overflow;
  logic [7:0]    drop_cnt;

  line_capture_if #(.DWIDTH(DW), .PWIDTH(PW)) ob ();

  line_capture #(.DWIDTH(DW), .PWIDTH(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .hsync    (hsync),
    .col      (col),
    .pix_in   (pix_in),
    .ob       (ob.master),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  logic [11:0] sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic          stall_q = 1'b0;
  logic [PW-1:0] pd = '0;
  logic [DW-1:0] pc = '0;
  logic [11:0]   e;

  // stream monitor: hold checks and scoreboard pop per accepted beat
  always @(negedge clk) begin
    if (!rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", ob.out_valid, 1);
        chk("hold_data", ob.out_data, pd);
        chk("hold_col", ob.out_col, pc);
      end
      if (ob.out_valid && ob.out_ready) begin
        e = (sbq.size() > 0) ? sbq.pop_front() : 12'hxxx;
        chk("beat", {ob.out_last, ob.out_col, ob.out_data}, e);
      end
      stall_q = ob.out_valid && !ob.out_ready;
      pd = ob.out_data;
      pc = ob.out_col;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input logic [PW-1:0] base, input int n,
                            input bit push);
    logic [PW-1:0] p;
    logic [11:0]   x;
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = base + PW'(i);
      col = DW'(i);
      pix_in = p;
      x = {1'(i == 7), DW'(i), p};
      if (push) sbq.push_back(x);
      tick();
    end
  endtask

  task automatic drain(input bit bp, input int maxc);
    for (int k = 0; k < maxc; k++) begin
      ob.out_ready = bp ? (k % 3 == 0) : 1'b1;
      tick();
      if (sbq.size() == 0 && !ob.out_valid) break;
    end
    chk("drain_queue", sbq.size(), 0);
    chk("drain_idle", ob.out_valid, 0);
  endtask

  initial begin
    int w;
    ob.out_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (3) tick();
    chk("rst_valid", ob.out_valid, 0);
    chk("rst_last", ob.out_last, 0);
    chk("rst_data", ob.out_data, 0);
    chk("rst_col", ob.out_col, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b1;
    repeat (20) begin
      tick();
      chk("idle_valid", ob.out_valid, 0);
      chk("idle_ovf", overflow, 0);
      chk("idle_drop", drop_cnt, 0);
    end

    ob.out_ready = 1'b1;
    write_line(8'h10, 8, 1'b1);
    chk("lat_e0", ob.out_valid, 0);
    tick();
    chk("lat_e1", ob.out_valid, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("burst_valid", ob.out_valid, 1);
      chk("burst_last", ob.out_last, (i == 7));
      tick();
    end
    chk("burst_end", ob.out_valid, 0);
    chk("burst_queue", sbq.size(), 0);

    ob.out_ready = 1'b0;
    write_line(8'h10, 8, 1'b1);
    drain(1'b1, 100);

    ob.out_ready = 1'b0;
    write_line(8'hA0, 8, 1'b1);
    write_line(8'hB0, 8, 1'b1);
    chk("pp_ovf0", overflow, 0);
    write_line(8'hEE, 8, 1'b0);
    chk("pp_ovf1", overflow, 1);
    chk("pp_drop1", drop_cnt, 1);
    chk("pp_stall", ob.out_data, 8'hA0);
    drain(1'b0, 100);

    write_line(8'h55, 5, 1'b0);
    write_line(8'h66, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      col = DW'(i);
      pix_in = 8'h66;
      sbq.push_back({1'(i == 7), DW'(i), 8'h66});
      tick();
    end
    drain(1'b0, 100);
    chk("ovf_sticky", overflow, 1);
    chk("drop_kept", drop_cnt, 1);

    ob.out_ready = 1'b1;
    write_line(8'hC0, 8, 1'b1);
    w = 0;
    while (!(ob.out_valid && ob.out_col == 3) && w < 20) begin
      tick();
      w++;
    end
    chk("reach_col3", {ob.out_valid, ob.out_col}, {1'b1, 3'd3});
    #2 rst = 1'b0;
    #1;
    chk("async_valid", ob.out_valid, 0);
    chk("async_ovf", overflow, 0);
    chk("async_drop", drop_cnt, 0);
    sbq.delete();
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) begin
      tick();
      chk("post_rst_idle", ob.out_valid, 0);
    end
    write_line(8'hD0, 8, 1'b1);
    drain(1'b0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
